// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants and types for the instruction-side AXI read bridge.
// The cancel/discard feature is built only when INST_BRIDGE_CANCEL_EN is defined (off by default).
package inst_axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
    } ar_req_t;

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Bus bundles for the bridge: IF-stage sram-like fetch port and the AXI read channels.
// master = initiator side, slave = responder side of each bundle.
interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addrok;
    logic        inst_sram_dataok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addrok, inst_sram_dataok, inst_sram_rdata
    );
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addrok, inst_sram_dataok, inst_sram_rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_axi_bridge_rd_tracker.sv
// In-flight read accounting: outstanding count, and (with INST_BRIDGE_CANCEL_EN)
// the count of stale beats to drop plus the ghost flag for an AR caught by a flush.
module inst_axi_rd_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cancel,
    input  logic ar_wait,
    input  logic ar_hs,
    input  logic r_hs,
    input  logic r_last_hs,
    output logic can_issue,
    output logic discard_now,
    output logic ghost
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [2:0] out_cnt;
    logic [2:0] out_cnt_next;

    always_comb begin
        out_cnt_next = out_cnt;
        if (ar_hs && !r_last_hs)
            out_cnt_next = out_cnt + 3'd1;
        else if (!ar_hs && r_last_hs)
            out_cnt_next = out_cnt - 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_cnt <= '0;
        else
            out_cnt <= out_cnt_next;
    end

    // A beat returning this cycle frees its slot for a request latched in the same cycle.
    assign can_issue = (out_cnt < MAX_CNT) || r_last_hs;

`ifdef INST_BRIDGE_CANCEL_EN
    logic [2:0] disc_cnt;
    logic [2:0] disc_next;
    logic       ghost_q;
    logic       ghost_next;

    // A cancel snapshots everything in flight including this cycle's handshakes;
    // an AR still waiting is marked ghost and joins the discard count when it completes.
    always_comb begin
        disc_next  = disc_cnt;
        ghost_next = ghost_q;
        if (ar_hs)
            ghost_next = 1'b0;
        if (cancel) begin
            disc_next = out_cnt_next;
            if (ar_wait && !ar_hs)
                ghost_next = 1'b1;
        end else begin
            if (r_hs && (disc_cnt != '0))
                disc_next = disc_next - 3'd1;
            if (ghost_q && ar_hs)
                disc_next = disc_next + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disc_cnt <= '0;
            ghost_q  <= 1'b0;
        end else begin
            disc_cnt <= disc_next;
            ghost_q  <= ghost_next;
        end
    end

    assign discard_now = (disc_cnt != '0);
    assign ghost       = ghost_q;
`else
    logic unused_tracker;
    assign unused_tracker = ^{cancel, ar_wait, r_hs};

    assign discard_now = 1'b0;
    assign ghost       = 1'b0;
`endif

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction fetch bridge: each sram-like fetch becomes one single-beat AXI read, returned in order.
// Optional flush support is compiled in with INST_BRIDGE_CANCEL_EN.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  AR_ID           = 4'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cancel,
    inst_sram_if.slave   sram,
    axi_rd_if.master     axi
);

    ar_state_t state;
    ar_state_t state_next;
    ar_req_t   ar_q;

    logic accept;
    logic can_issue;
    logic discard_now;
    logic ghost;
    logic ar_hs;
    logic r_hs;
    logic r_last_hs;

    assign accept = (state == AR_IDLE) && sram.inst_sram_req && can_issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= AR_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            AR_IDLE: if (accept)      state_next = AR_WAIT;
            AR_WAIT: if (axi.arready) state_next = AR_IDLE;
            default:                  state_next = AR_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid = (state == AR_WAIT);
        axi.araddr  = ar_q.addr;
        axi.arsize  = {1'b0, ar_q.size};
        axi.arid    = AR_ID;
        axi.arlen   = '0;
        axi.arburst = AXI_BURST_INCR;
        axi.arlock  = '0;
        axi.arcache = '0;
        axi.arprot  = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ar_q <= '0;
        else if (accept)
            ar_q <= '{addr: sram.inst_sram_addr, size: sram.inst_sram_size};
    end

    assign ar_hs     = axi.arvalid && axi.arready;
    assign r_hs      = axi.rvalid && axi.rready;
    assign r_last_hs = r_hs && axi.rlast;

    assign axi.rready = !reset;

    assign sram.inst_sram_addrok = ar_hs && !ghost;
    assign sram.inst_sram_dataok = r_hs && !discard_now;
    assign sram.inst_sram_rdata  = axi.rdata;

    logic unused_inputs;
    assign unused_inputs = ^{sram.inst_sram_wr, sram.inst_sram_wstrb, sram.inst_sram_wdata,
                             axi.rid, axi.rresp};

    inst_axi_rd_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_trk (
        .clk        (clk),
        .reset      (reset),
        .cancel     (cancel),
        .ar_wait    (state == AR_WAIT),
        .ar_hs      (ar_hs),
        .r_hs       (r_hs),
        .r_last_hs  (r_last_hs),
        .can_issue  (can_issue),
        .discard_now(discard_now),
        .ghost      (ghost)
    );

endmodule
